// File: rtl/fib_spi_tx.sv
// Frame-buffered SPI transmitter: captures a contiguous burst of FRAME_BYTES bytes
// from the FIB, then shifts them out MSB-first on a mode-0 SPI link.
module fib_spi_tx #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       ready,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       frame_done,
    output logic       short_err,
    output logic       overrun
);

    localparam int NBITS = 8 * FRAME_BYTES;
    localparam int CW    = $clog2(FRAME_BYTES);
    localparam int BW    = $clog2(NBITS);

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, HOLD} state_t;

    state_t        state;
    logic [7:0]    frame_buf [FRAME_BYTES];
    logic [CW-1:0] count;
    logic [BW-1:0] bit_idx;
    logic [BW-1:0] nxt_idx;
    logic [7:0]    div_cnt;
    logic          store;
    logic [CW-1:0] wr_idx;
    logic          nxt_bit;

    assign store   = in_valid && ((state == IDLE && ready) || state == CAPTURE);
    assign wr_idx  = (state == CAPTURE) ? count : '0;
    assign nxt_idx = bit_idx + 1'b1;
    assign nxt_bit = frame_buf[nxt_idx[BW-1:3]][~nxt_idx[2:0]];

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (store)
            frame_buf[wr_idx] <= in_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            frame_done <= 1'b0;
            short_err  <= 1'b0;
            overrun    <= 1'b0;
            count      <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            short_err  <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                // ready is still low in the frame_done cycle, so a byte there is an overrun
                IDLE: begin
                    if (!ready) begin
                        ready   <= 1'b1;
                        overrun <= in_valid & ~overrun;
                    end else if (in_valid) begin
                        ready <= 1'b0;
                        count <= CW'(1);
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        if (count == CW'(FRAME_BYTES - 1)) begin
                            state    <= SHIFT;
                            spi_cs_n <= 1'b0;
                            spi_sclk <= 1'b0;
                            spi_mosi <= frame_buf[0][7];
                            div_cnt  <= '0;
                            bit_idx  <= '0;
                            count    <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        short_err <= 1'b1;
                        ready     <= 1'b1;
                        count     <= '0;
                        state     <= IDLE;
                    end
                end
                // Data moves only on the falling SCLK edge so it is stable at every rise.
                SHIFT: begin
                    overrun <= in_valid & ~overrun;
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        if (spi_sclk) begin
                            if (bit_idx == BW'(NBITS - 1)) begin
                                state <= HOLD;
                            end else begin
                                bit_idx  <= nxt_idx;
                                spi_mosi <= nxt_bit;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    overrun <= in_valid & ~overrun;
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt    <= '0;
                        spi_cs_n   <= 1'b1;
                        spi_mosi   <= 1'b0;
                        frame_done <= 1'b1;
                        bit_idx    <= '0;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_spi_tx.sv
// Bench for fib_spi_tx: two instances (CLK_DIV 4 and 2) driven with random and directed
// frames; a passive monitor decodes the SPI line and flags protocol violations.
module tb_fib_spi_tx;

    typedef logic [7:0] frame_t [17];

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] iv;
    logic [7:0] ib [2];
    logic [1:0] rdy, cs_n, sclk, mosi, dn, se, ov;

    int divs [2] = '{4, 2};
    int compared = 0;
    int mismatched = 0;

    int rise_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int ovr_cnt  [2] = '{0, 0};
    int serr_cnt [2] = '{0, 0};
    int prot_err [2] = '{0, 0};
    int run      [2] = '{0, 0};
    int hp       [2] = '{0, 0};
    int last_low [2] = '{0, 0};
    logic [1:0] p_cs = 2'b11, p_sclk = 2'b00, p_mosi = 2'b00, p_dn = 2'b00, p_se = 2'b00, p_ov = 2'b00;
    bit rx [2][2048];

    always #5 clk = ~clk;

    fib_spi_tx #(.CLK_DIV(4), .FRAME_BYTES(17)) u_div4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_byte(ib[0]), .ready(rdy[0]),
        .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
        .frame_done(dn[0]), .short_err(se[0]), .overrun(ov[0])
    );

    fib_spi_tx #(.CLK_DIV(2), .FRAME_BYTES(17)) u_div2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_byte(ib[1]), .ready(rdy[1]),
        .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
        .frame_done(dn[1]), .short_err(se[1]), .overrun(ov[1])
    );

    // Line monitor: half-period timing, MOSI stability, idle levels and pulse widths.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cs_n[g]) begin
                if (p_cs[g]) begin
                    run[g] <= 1;
                    hp[g]  <= 0;
                end else begin
                    run[g] <= run[g] + 1;
                    if (sclk[g] != p_sclk[g]) begin
                        if (hp[g] + 1 != divs[g]) prot_err[g] <= prot_err[g] + 1;
                        hp[g] <= 0;
                    end else begin
                        hp[g] <= hp[g] + 1;
                    end
                    if (mosi[g] != p_mosi[g] && !(p_sclk[g] && !sclk[g]))
                        prot_err[g] <= prot_err[g] + 1;
                end
            end else begin
                if (!p_cs[g]) begin
                    last_low[g] <= run[g];
                    if (dn[g] && hp[g] + 1 != divs[g]) prot_err[g] <= prot_err[g] + 1;
                end
                if (mosi[g] || sclk[g]) prot_err[g] <= prot_err[g] + 1;
            end
            if (sclk[g] && !p_sclk[g]) begin
                rx[g][rise_cnt[g] & 2047] <= mosi[g];
                rise_cnt[g] <= rise_cnt[g] + 1;
                if (cs_n[g] || mosi[g] != p_mosi[g]) prot_err[g] <= prot_err[g] + 1;
            end
            if (dn[g]) begin
                done_cnt[g] <= done_cnt[g] + 1;
                if (p_dn[g] || !(cs_n[g] && !p_cs[g])) prot_err[g] <= prot_err[g] + 1;
            end
            if (ov[g]) begin
                ovr_cnt[g] <= ovr_cnt[g] + 1;
                if (p_ov[g]) prot_err[g] <= prot_err[g] + 1;
            end
            if (se[g]) begin
                serr_cnt[g] <= serr_cnt[g] + 1;
                if (p_se[g]) prot_err[g] <= prot_err[g] + 1;
            end
            if (rdy[g] && !cs_n[g]) prot_err[g] <= prot_err[g] + 1;
        end
        p_cs   <= cs_n;
        p_sclk <= sclk;
        p_mosi <= mosi;
        p_dn   <= dn;
        p_se   <= se;
        p_ov   <= ov;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        if (obs != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic applyStimulus(input int g, input frame_t f, input int n);
        for (int i = 0; i < n; i++) begin
            iv[g] = 1'b1;
            ib[g] = f[i];
            tick();
        end
        iv[g] = 1'b0;
    endtask

    task automatic waitDone(input int g, input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (dn[g]) seen = 1;
        end
        checkOutput({tag, "_done_seen"}, int'(seen), 1);
    endtask

    // Reference: bit k of the frame is byte k/8, bit 7-(k%8); rebuild each byte from decoded rises.
    task automatic verifyFrame(input int g, input frame_t f, input int start, input string tag);
        logic [7:0] got;
        for (int i = 0; i < 17; i++) begin
            got = 8'h00;
            for (int j = 0; j < 8; j++)
                got = {got[6:0], rx[g][(start + 8 * i + j) & 2047]};
            checkOutput($sformatf("%s_byte%0d", tag, i), int'(got), int'(f[i]));
        end
    endtask

    task automatic runFrame(input int g, input frame_t f, input int n_ovr, input string tag);
        int s = rise_cnt[g];
        int d = done_cnt[g];
        int o = ovr_cnt[g];
        applyStimulus(g, f, 17);
        if (n_ovr > 0) begin
            repeat (60) tick();
            for (int k = 0; k < n_ovr; k++) begin
                iv[g] = 1'b1;
                ib[g] = 8'($urandom);
                tick();
                iv[g] = 1'b0;
                repeat (5) tick();
            end
        end
        waitDone(g, 4000, tag);
        checkOutput({tag, "_ready_in_done"}, int'(rdy[g]), 0);
        tick();
        checkOutput({tag, "_ready_after"}, int'(rdy[g]), 1);
        checkOutput({tag, "_cs_low_cycles"}, last_low[g], divs[g] * 273);
        checkOutput({tag, "_rises"}, rise_cnt[g] - s, 136);
        checkOutput({tag, "_done_cnt"}, done_cnt[g] - d, 1);
        checkOutput({tag, "_overruns"}, ovr_cnt[g] - o, n_ovr);
        verifyFrame(g, f, s, tag);
    endtask

    initial begin
        frame_t f, fa, fb;
        int s, d, o, e;
        bit hit;

        rst = 1'b1;
        iv = 2'b00;
        ib[0] = 8'h00;
        ib[1] = 8'h00;
        repeat (3) tick();
        checkOutput("rst_ready", int'(rdy), 3);
        checkOutput("rst_cs_n", int'(cs_n), 3);
        checkOutput("rst_sclk", int'(sclk), 0);
        checkOutput("rst_mosi", int'(mosi), 0);
        checkOutput("rst_pulses", int'({dn, se, ov}), 0);
        rst = 1'b0;
        tick();

        f[0] = 8'hA5;
        for (int i = 1; i < 17; i++) f[i] = 8'(i - 1);
        runFrame(0, f, 0, "known");

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
            runFrame(0, f, 0, $sformatf("rand%0d", r));
        end

        // Burst of 9 bytes then a gap: short frame is dropped
        for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
        e = serr_cnt[0];
        applyStimulus(0, f, 9);
        tick();
        checkOutput("short_err_pulse", int'(se[0]), 1);
        checkOutput("short_cs_idle", int'(cs_n[0]), 1);
        tick();
        checkOutput("short_err_single", int'(se[0]), 0);
        checkOutput("short_ready", int'(rdy[0]), 1);
        checkOutput("short_err_count", serr_cnt[0] - e, 1);
        for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
        runFrame(0, f, 0, "after_short");

        for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
        runFrame(0, f, 3, "overrun");

        // Reset around SCLK rise 50 aborts silently
        for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
        s = rise_cnt[0];
        d = done_cnt[0];
        e = serr_cnt[0];
        applyStimulus(0, f, 17);
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (rise_cnt[0] - s >= 50) hit = 1;
        end
        checkOutput("rst50_reached", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst50_cs_n", int'(cs_n[0]), 1);
        checkOutput("rst50_sclk", int'(sclk[0]), 0);
        checkOutput("rst50_mosi", int'(mosi[0]), 0);
        checkOutput("rst50_ready", int'(rdy[0]), 1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("rst50_no_done", done_cnt[0] - d, 0);
        checkOutput("rst50_no_err", serr_cnt[0] - e, 0);
        for (int i = 0; i < 17; i++) f[i] = 8'hFF;
        runFrame(0, f, 0, "ones");

        // Second frame starts in the first ready cycle after frame_done
        for (int i = 0; i < 17; i++) begin
            fa[i] = 8'($urandom);
            fb[i] = 8'($urandom);
        end
        s = rise_cnt[0];
        d = done_cnt[0];
        o = ovr_cnt[0];
        applyStimulus(0, fa, 17);
        waitDone(0, 4000, "b2b_a");
        tick();
        checkOutput("b2b_ready", int'(rdy[0]), 1);
        applyStimulus(0, fb, 17);
        waitDone(0, 4000, "b2b_b");
        tick();
        checkOutput("b2b_done_cnt", done_cnt[0] - d, 2);
        checkOutput("b2b_overruns", ovr_cnt[0] - o, 0);
        checkOutput("b2b_rises", rise_cnt[0] - s, 272);
        verifyFrame(0, fa, s, "b2b_a");
        verifyFrame(0, fb, s + 136, "b2b_b");

        for (int i = 0; i < 17; i++) f[i] = (i % 2 == 0) ? 8'h55 : 8'hAA;
        runFrame(1, f, 0, "div2_alt");

        // A byte in the frame_done cycle is an overrun and starts nothing
        for (int i = 0; i < 17; i++) f[i] = 8'($urandom);
        s = rise_cnt[1];
        e = serr_cnt[1];
        applyStimulus(1, f, 17);
        waitDone(1, 4000, "div2_edge");
        iv[1] = 1'b1;
        ib[1] = 8'($urandom);
        tick();
        iv[1] = 1'b0;
        checkOutput("edge_overrun", int'(ov[1]), 1);
        checkOutput("edge_ready", int'(rdy[1]), 1);
        repeat (20) tick();
        checkOutput("edge_cs_idle", int'(cs_n[1]), 1);
        checkOutput("edge_no_short", serr_cnt[1] - e, 0);
        checkOutput("edge_rises", rise_cnt[1] - s, 136);
        verifyFrame(1, f, s, "div2_edge");

        checkOutput("protocol_div4", prot_err[0], 0);
        checkOutput("protocol_div2", prot_err[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
